// File: rtl/uart_rx.sv
// 8N1 serial receiver with a show-ahead receive FIFO; frame errors and overruns reported as pulses.
// Latency: 2-cycle pin synchronizer + 1-cycle edge detect; byte visible one cycle after the stop sample.
// Backpressure: none on the line; a good byte arriving while the FIFO is full is dropped and flagged.
module uart_rx #(
    parameter int DEPTH = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] baud_div_i,
    input  logic        rx_en_i,
    input  logic        rx_bit_i,
    input  logic        rx_re_i,
    output logic [7:0]  dout_o,
    output logic        full_o,
    output logic        empty_o,
    output logic        frame_err_o,
    output logic        overrun_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q, rxs_q;
    logic        rxs, fall_edge;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] half;
    logic        start_tick, bit_tick;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic        push, pop;
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];

    assign rxs        = sync2_q;
    assign fall_edge  = rxs_q & ~rxs;
    assign half       = baud_div_i >> 1;
    assign start_tick = (cnt_q == half - 16'd1);
    assign bit_tick   = (cnt_q == baud_div_i - 16'd1);

    // Pin synchronizer and previous-value register; idle-high reset so no spurious edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rx_bit_i;
            sync2_q <= sync1_q;
            rxs_q   <= rxs;
        end
    end

    // FSM state and receive datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Next-state: disable overrides everything; a high start sample is treated as a glitch
    always_comb begin
        state_d = state_q;
        if (!rx_en_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (fall_edge) state_d = S_START;
                S_START: if (start_tick) state_d = rxs ? S_IDLE : S_DATA;
                S_DATA:  if (bit_tick && bit_cnt_q == 4'd7) state_d = S_STOP;
                S_STOP:  if (bit_tick) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs of the FSM: counter, bit shifting, push decision and error pulses
    always_comb begin
        cnt_d       = cnt_q + 16'd1;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        if (!rx_en_i) begin
            cnt_d     = '0;
            bit_cnt_d = '0;
        end else begin
            if (state_d != state_q) cnt_d = '0;
            case (state_q)
                S_START: begin
                    if (start_tick && !rxs) bit_cnt_d = '0;
                end
                S_DATA: begin
                    // Each data sample restarts the bit timer so samples stay one bit apart
                    if (bit_tick) begin
                        shift_d   = {rxs, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        cnt_d     = '0;
                    end
                end
                S_STOP: begin
                    if (bit_tick) begin
                        if (!rxs)        frame_err_d = 1'b1;
                        else if (full_o) overrun_d   = 1'b1;
                        else             push        = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // FIFO pointer update; pop when empty is ignored, push fullness judged on current full_o
    always_comb begin
        pop      = rx_re_i & ~empty_o;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    // FIFO storage, deliberately left unreset
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end

    assign empty_o     = (wr_ptr_q == rd_ptr_q);
    assign full_o      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout_o      = empty_o ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1 frames at 16 cycles per bit, exact push timing,
// glitch rejection, frame error with break, overrun and wrap, disable and reset mid-frame.
module tb_uart_rx;

    localparam int BAUD = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [15:0] baud_div_i = 16'(BAUD);
    logic        rx_en_i = 1'b1;
    logic        rx_bit_i = 1'b1;
    logic        rx_re_i = 1'b0;
    logic [7:0]  dout_o;
    logic        full_o, empty_o, frame_err_o, overrun_o;

    int tests_run = 0;
    int tests_failed = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    uart_rx #(.DEPTH(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .baud_div_i(baud_div_i),
        .rx_en_i(rx_en_i), .rx_bit_i(rx_bit_i), .rx_re_i(rx_re_i),
        .dout_o(dout_o), .full_o(full_o), .empty_o(empty_o),
        .frame_err_o(frame_err_o), .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (frame_err_o) fe_cnt++;
        if (overrun_o)   ov_cnt++;
    end

    task automatic drive_bit(input logic v);
        rx_bit_i = v;
        repeat (BAUD) @(negedge clk_i);
    endtask

    task automatic send_head(input logic [7:0] b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        send_head(b);
        drive_bit(stop_bit);
    endtask

    // pops one entry: one rx_re_i cycle, returns at a negedge after the pop edge
    task automatic pop_one;
        rx_re_i = 1'b1;
        @(negedge clk_i);
        rx_re_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        tests_run++; if (dout_o !== 8'h00) begin tests_failed++; $display("FAIL reset_dout got %h want 00", dout_o); end
        tests_run++; if (empty_o !== 1'b1) begin tests_failed++; $display("FAIL reset_empty got %b want 1", empty_o); end
        tests_run++; if (full_o !== 1'b0) begin tests_failed++; $display("FAIL reset_full got %b want 0", full_o); end
        tests_run++; if (frame_err_o !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err got %b want 0", frame_err_o); end
        tests_run++; if (overrun_o !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun got %b want 0", overrun_o); end
        rst_ni = 1'b1;
        repeat (4) @(negedge clk_i);
    endtask

    task automatic test_single;
        // Start bit launched at negedge E; stop sample lands on the 155th posedge after E.
        // After send_head returns (negedge 144), posedge 154 is 10 edges away.
        send_head(8'hA5);
        rx_bit_i = 1'b1;
        repeat (10) @(posedge clk_i);
        #1;
        tests_run++; if (empty_o !== 1'b1) begin tests_failed++; $display("FAIL single_empty_before got %b want 1", empty_o); end
        @(posedge clk_i);
        #1;
        tests_run++; if (empty_o !== 1'b0) begin tests_failed++; $display("FAIL single_empty_after got %b want 0", empty_o); end
        tests_run++; if (dout_o !== 8'hA5) begin tests_failed++; $display("FAIL single_dout got %h want a5", dout_o); end
        repeat (8) @(negedge clk_i);
        pop_one();
        tests_run++; if (empty_o !== 1'b1) begin tests_failed++; $display("FAIL single_pop_empty got %b want 1", empty_o); end
        tests_run++; if (dout_o !== 8'h00) begin tests_failed++; $display("FAIL single_pop_dout got %h want 00", dout_o); end
    endtask

    task automatic test_glitch;
        int fe0, ov0;
        fe0 = fe_cnt; ov0 = ov_cnt;
        rx_bit_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rx_bit_i = 1'b1;
        repeat (40) @(negedge clk_i);
        tests_run++; if (empty_o !== 1'b1) begin tests_failed++; $display("FAIL glitch_empty got %b want 1", empty_o); end
        tests_run++; if ((fe_cnt - fe0) !== 0 || (ov_cnt - ov0) !== 0) begin tests_failed++; $display("FAIL glitch_pulses got fe=%0d ov=%0d want 0 0", fe_cnt - fe0, ov_cnt - ov0); end
        send_frame(8'h3C, 1'b1);
        repeat (2) @(negedge clk_i);
        tests_run++; if (dout_o !== 8'h3C) begin tests_failed++; $display("FAIL glitch_next_dout got %h want 3c", dout_o); end
        pop_one();
        tests_run++; if (empty_o !== 1'b1) begin tests_failed++; $display("FAIL glitch_next_empty got %b want 1", empty_o); end
    endtask

    task automatic test_frame_err;
        int fe0;
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (40) @(negedge clk_i);
        tests_run++; if ((fe_cnt - fe0) !== 1) begin tests_failed++; $display("FAIL frame_err_count got %0d want 1", fe_cnt - fe0); end
        tests_run++; if (empty_o !== 1'b1) begin tests_failed++; $display("FAIL frame_err_empty got %b want 1", empty_o); end
        rx_bit_i = 1'b1;
        repeat (20) @(negedge clk_i);
        send_frame(8'h55, 1'b1);
        repeat (2) @(negedge clk_i);
        tests_run++; if (dout_o !== 8'h55) begin tests_failed++; $display("FAIL frame_err_next got %h want 55", dout_o); end
        tests_run++; if ((fe_cnt - fe0) !== 1) begin tests_failed++; $display("FAIL frame_err_no_retrigger got %0d want 1", fe_cnt - fe0); end
        pop_one();
    endtask

    task automatic test_overrun_wrap;
        int ov0;
        logic [7:0] b;
        ov0 = ov_cnt;
        for (int i = 0; i < 32; i++) begin
            b = 8'(i);
            send_frame(b, 1'b1);
        end
        tests_run++; if (full_o !== 1'b1) begin tests_failed++; $display("FAIL ovr_full got %b want 1", full_o); end
        tests_run++; if ((ov_cnt - ov0) !== 0) begin tests_failed++; $display("FAIL ovr_early got %0d want 0", ov_cnt - ov0); end
        send_frame(8'h20, 1'b1);
        tests_run++; if ((ov_cnt - ov0) !== 1) begin tests_failed++; $display("FAIL ovr_count got %0d want 1", ov_cnt - ov0); end
        tests_run++; if (full_o !== 1'b1) begin tests_failed++; $display("FAIL ovr_still_full got %b want 1", full_o); end
        for (int i = 0; i < 32; i++) begin
            b = 8'(i);
            tests_run++; if (dout_o !== b) begin tests_failed++; $display("FAIL ovr_drain[%0d] got %h want %h", i, dout_o, b); end
            pop_one();
        end
        tests_run++; if (empty_o !== 1'b1) begin tests_failed++; $display("FAIL ovr_drained got %b want 1", empty_o); end
        for (int i = 0; i < 3; i++) begin
            b = 8'hE0 + 8'(i);
            send_frame(b, 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            b = 8'hE0 + 8'(i);
            tests_run++; if (dout_o !== b) begin tests_failed++; $display("FAIL wrap[%0d] got %h want %h", i, dout_o, b); end
            pop_one();
        end
        tests_run++; if (empty_o !== 1'b1) begin tests_failed++; $display("FAIL wrap_empty got %b want 1", empty_o); end
    endtask

    task automatic test_disable;
        int fe0, ov0;
        logic [7:0] b;
        fe0 = fe_cnt; ov0 = ov_cnt;
        b = 8'h0F;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx_en_i = 1'b0;
        rx_bit_i = 1'b1;
        repeat (2 * BAUD) @(negedge clk_i);
        rx_en_i = 1'b1;
        repeat (4) @(negedge clk_i);
        send_frame(8'h81, 1'b1);
        repeat (2) @(negedge clk_i);
        tests_run++; if (dout_o !== 8'h81) begin tests_failed++; $display("FAIL disable_dout got %h want 81", dout_o); end
        pop_one();
        tests_run++; if (empty_o !== 1'b1) begin tests_failed++; $display("FAIL disable_only_one got %b want 1", empty_o); end
        tests_run++; if ((fe_cnt - fe0) !== 0 || (ov_cnt - ov0) !== 0) begin tests_failed++; $display("FAIL disable_pulses got fe=%0d ov=%0d want 0 0", fe_cnt - fe0, ov_cnt - ov0); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] b;
        send_frame(8'h11, 1'b1);
        repeat (2) @(negedge clk_i);
        tests_run++; if (empty_o !== 1'b0) begin tests_failed++; $display("FAIL rstmid_prefill got %b want 0", empty_o); end
        b = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(b[i]);
        rst_ni = 1'b0;
        #1;
        tests_run++; if (empty_o !== 1'b1 || full_o !== 1'b0 || dout_o !== 8'h00) begin tests_failed++; $display("FAIL rstmid_outputs got empty=%b full=%b dout=%h want 1 0 00", empty_o, full_o, dout_o); end
        tests_run++; if (frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin tests_failed++; $display("FAIL rstmid_pulses got fe=%b ov=%b want 0 0", frame_err_o, overrun_o); end
        rx_bit_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (5) @(negedge clk_i);
        send_frame(8'hC3, 1'b1);
        repeat (2) @(negedge clk_i);
        tests_run++; if (dout_o !== 8'hC3) begin tests_failed++; $display("FAIL rstmid_next got %h want c3", dout_o); end
        pop_one();
        tests_run++; if (empty_o !== 1'b1) begin tests_failed++; $display("FAIL rstmid_empty got %b want 1", empty_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun_wrap();
        test_disable();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive half of the TCORE UART peripheral. Recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, line idle high) from the `rx_bit_i` pin, using the same `baud_div_i` cycles-per-bit divisor as the transmitter. Each valid byte goes into a 32-entry receive FIFO that the UART register interface drains. Frame errors and overruns are reported as single-cycle pulses.

## Interface
- `DEPTH`, 32: receive FIFO depth in bytes; must be a power of two.
- `clk_i`  in  1  system clock; the only clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `baud_div_i`  in  16  clock cycles per bit; legal range ≥ 4; behaviour undefined below 4.
- `rx_en_i`  in  1  receiver enable.
- `rx_bit_i`  in  1  asynchronous serial input pin.
- `rx_re_i`  in  1  FIFO read enable; pops the head entry when `empty_o` = 0.
- `dout_o`  out  8  FIFO head byte (show-ahead); 8'h00 while `empty_o` = 1.
- `full_o`  out  1  FIFO holds `DEPTH` bytes.
- `empty_o`  out  1  FIFO holds 0 bytes.
- `frame_err_o`  out  1  one-cycle pulse: the stop bit was sampled low.
- `overrun_o`  out  1  one-cycle pulse: a good byte was dropped because the FIFO was full.

## Operation
- **Input synchronizer:** 2-flop synchronizer on `rx_bit_i`, reset to 1. All logic uses only the synchronized bit `rxs`. A registered copy of the previous value, `rxs_q` (reset 1), is used for edge detection.
- **Start detection:** a start is detected when `rxs_q` = 1 and `rxs` = 0.
- **Baud counter:** 16-bit, cleared on every state change, increments every cycle otherwise. `half` = `baud_div_i >> 1`.
- **FSM states:**
  - **IDLE:** go to START on a falling edge while `rx_en_i` = 1.
  - **START:** when counter = `half` − 1, sample `rxs`.
    - If 1: glitch; return to IDLE with no report.
    - If 0: go to DATA; clear `bit_cnt`.
  - **DATA:** when counter = `baud_div_i` − 1, sample `rxs` into a shift register (right shift, new bit enters bit 7) and increment `bit_cnt`. After the 8th sample (`bit_cnt` = 7 → 8), go to STOP.
  - **STOP:** when counter = `baud_div_i` − 1, sample `rxs`, then go to IDLE.
    - If 1 and FIFO not full: push the byte.
    - If 1 and FIFO full: discard the byte; pulse `overrun_o`.
    - If 0: discard the byte; pulse `frame_err_o`.
- **Sample points:** every sample lands at the middle of its bit, ±1 cycle.
- **Break handling:** a line held low after a frame error does not retrigger. Re-arming needs `rxs` back at 1 followed by a new falling edge.
- **Receiver disable:** `rx_en_i` = 0 in any state forces IDLE, clears the counter and `bit_cnt`, and drops any partial frame. FIFO contents are kept.
- **FIFO pointers:** `$clog2(DEPTH)+1`-bit read and write pointers.
  - `empty_o` = pointers equal.
  - `full_o` = MSBs differ and the low bits are equal.
  - Index wrap-around is natural.
- **Simultaneous push and pop:** both take effect in the same cycle. Fullness for a push is judged on the current `full_o`, so a push when full is an overrun even if a pop happens in the same cycle.
- **Pop when empty:** ignored.
- **Storage:** FIFO storage is not reset.

## Timing
- **Reset values:** `dout_o` = 00, `empty_o` = 1, `full_o` = 0, `frame_err_o` = 0, `overrun_o` = 0; FSM in IDLE; pointers and counters 0.
- **Reset mid-frame:** the frame is aborted immediately and asynchronously. The next frame needs a fresh falling edge after reset is released.
- **Input latency:** 2 cycles from pin to `rxs`, plus 1 cycle to the edge detect.
- **Frame length:** the stop sample falls `half` + 9·`baud_div_i` cycles after the edge detect.
- **Push visibility:** a push lands on the stop-sample clock edge. `empty_o` falls and `dout_o` is valid one cycle later.
- **Error pulses:** `frame_err_o` and `overrun_o` assert for exactly the one cycle after the stop-sample edge.
- **Pop:** `rx_re_i` sampled high with `empty_o` = 0 advances the read pointer on that edge. The new head appears on `dout_o` the next cycle.
- **Back-to-back frames:** a frame whose start edge arrives right after the stop bit's midpoint is received without loss.
- **`baud_div_i` changes:** may only change while in IDLE.

## Test plan
- **Single byte:** `baud_div_i` = 16; drive 8N1 byte 0xA5 → `empty_o` = 0 one cycle after the stop sample; `dout_o` = A5; one `rx_re_i` pulse → `empty_o` = 1, `dout_o` = 00.
- **Start glitch:** low pulse of 4 cycles with `baud_div_i` = 16 → FSM back in IDLE; no push, no pulses. A following real frame 0x3C is received correctly.
- **Frame error:** frame 0x3C with stop bit 0, then line held low for 40 cycles → one `frame_err_o` pulse, FIFO stays empty, no retrigger. Line high, then frame 0x55 → 55 received.
- **Overrun and wrap:** 33 back-to-back frames 0x00..0x20, no reads → `full_o` = 1 after the 32nd; the 33rd gives one `overrun_o` pulse. Draining yields 00..1F in order. Then 3 more bytes 0xE0..0xE2 read back correctly across the pointer wrap.
- **Disable mid-frame:** `rx_en_i` dropped after 4 data bits, re-enabled, frame 0x81 sent → only 81 in the FIFO.
- **Reset mid-frame:** `rst_ni` asserted mid-DATA → all outputs at reset values immediately. The next frame 0xC3 is received correctly.
